// File: rtl/ahblite_decoder_mux.sv
// ahblite_decoder_mux
// AHB-Lite address decoder and slave-response multiplexer with a built-in
// default slave that answers unmapped NONSEQ/SEQ transfers with a two-cycle
// ERROR response.
// Optional error log (ERR_CNT / ERR_ADDR) is built only when the macro
// AHB_DEC_ERRLOG_EN is defined; otherwise both outputs are tied to zero.
module ahblite_decoder_mux #(
  parameter int                  NPORT     = 4,
  parameter logic [NPORT-1:0]    PORT_EN   = 4'hF,
  parameter logic [NPORT*16-1:0] BASE_ADDR = {16'h4001, 16'h4000, 16'h2000, 16'h0000},
  parameter logic [NPORT*16-1:0] ADDR_MASK = {4{16'hFFFF}}
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  output logic [NPORT-1:0]      HSEL,
  input  logic [NPORT-1:0]      HREADYOUT_S,
  input  logic [NPORT-1:0]      HRESP_S,
  input  logic [NPORT*32-1:0]   HRDATA_S,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [15:0]           ERR_CNT,
  output logic [31:0]           ERR_ADDR
);

  // Data-phase selection codes: 0..7 are port indices.
  localparam logic [3:0] SEL_DEF  = 4'd14;
  localparam logic [3:0] SEL_NONE = 4'd15;

  // Default-slave states.
  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_ERR1 = 2'd1;
  localparam logic [1:0] D_ERR2 = 2'd2;

  logic [NPORT-1:0] match_vec_s;
  logic             match_hit_s;
  logic [2:0]       match_idx_s;
  logic [NPORT-1:0] hsel_s;
  logic [3:0]       sel_nxt_s;
  logic [3:0]       sel_r;
  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             hready_s;
  logic             hresp_s;
  logic [31:0]      hrdata_s;
  logic             load_def_s;
  logic             unused_s;

  // Per-port address match and lowest-index priority encode.
  always_comb begin
    match_vec_s = '0;
    match_idx_s = 3'd0;
    for (int i = 0; i < NPORT; i++) begin
      match_vec_s[i] = PORT_EN[i] &&
        ((HADDR[31:16] & ADDR_MASK[16*i +: 16]) == (BASE_ADDR[16*i +: 16] & ADDR_MASK[16*i +: 16]));
    end
    // Walk from the top so the lowest matching index is written last.
    for (int i = NPORT - 1; i >= 0; i--) begin
      match_idx_s = match_vec_s[i] ? 3'(i) : match_idx_s;
    end
    match_hit_s = |match_vec_s;
  end

  // One-hot HSEL from the priority-encoded match.
  always_comb begin
    hsel_s = '0;
    for (int i = 0; i < NPORT; i++) begin
      hsel_s[i] = match_hit_s && (match_idx_s == 3'(i));
    end
  end

  assign HSEL = hsel_s;

  // Next data-phase selection for the current address phase.
  always_comb begin
    sel_nxt_s = SEL_NONE;
    if (match_hit_s) begin
      sel_nxt_s = {1'b0, match_idx_s};
    end else if (HTRANS[1]) begin
      sel_nxt_s = SEL_DEF;
    end else begin
      sel_nxt_s = SEL_NONE;
    end
  end

  // An unmapped active transfer is being accepted on this edge.
  assign load_def_s = hready_s && !match_hit_s && HTRANS[1];

  // Data-phase select register, loaded only when the bus is ready.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sel_r <= SEL_NONE;
    end else if (hready_s) begin
      sel_r <= sel_nxt_s;
    end else begin
      sel_r <= sel_r;
    end
  end

  // Default-slave next-state logic.
  always_comb begin
    state_nxt_s = D_IDLE;
    case (state_r)
      D_IDLE:  state_nxt_s = load_def_s ? D_ERR1 : D_IDLE;
      D_ERR1:  state_nxt_s = D_ERR2;
      D_ERR2:  state_nxt_s = load_def_s ? D_ERR1 : D_IDLE;
      default: state_nxt_s = D_IDLE;
    endcase
  end

  // Default-slave state register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_r <= D_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Response multiplexer driven by the data-phase selection.
  always_comb begin
    hready_s = 1'b1;
    hresp_s  = 1'b0;
    hrdata_s = 32'h0;
    for (int i = 0; i < NPORT; i++) begin
      hready_s = (sel_r == 4'(i)) ? HREADYOUT_S[i]       : hready_s;
      hresp_s  = (sel_r == 4'(i)) ? HRESP_S[i]           : hresp_s;
      hrdata_s = (sel_r == 4'(i)) ? HRDATA_S[32*i +: 32] : hrdata_s;
    end
    if (sel_r == SEL_DEF) begin
      hready_s = (state_r != D_ERR1);
      hresp_s  = (state_r == D_ERR1) || (state_r == D_ERR2);
      hrdata_s = 32'h0;
    end else begin
      hready_s = hready_s;
    end
  end

  assign HREADY = hready_s;
  assign HRESP  = hresp_s;
  assign HRDATA = hrdata_s;

`ifdef AHB_DEC_ERRLOG_EN
  logic [15:0] err_cnt_r;
  logic [31:0] err_addr_r;

  // Error log: count default-slave entries and remember the faulting address.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      err_cnt_r  <= 16'h0;
      err_addr_r <= 32'h0;
    end else if (load_def_s) begin
      err_cnt_r  <= (err_cnt_r == 16'hFFFF) ? err_cnt_r : err_cnt_r + 16'd1;
      err_addr_r <= HADDR;
    end else begin
      err_cnt_r  <= err_cnt_r;
      err_addr_r <= err_addr_r;
    end
  end

  assign ERR_CNT  = err_cnt_r;
  assign ERR_ADDR = err_addr_r;
  assign unused_s = HTRANS[0];
`else
  assign ERR_CNT  = 16'h0;
  assign ERR_ADDR = 32'h0;
  assign unused_s = ^{HADDR[15:0], HTRANS[0]};
`endif

endmodule
